// File: rtl/param_ring_counter_pkg.sv
// Shared constants and seed/period helpers for the parametrised ring/Johnson counter.
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_LEFT     = 1'b0;
  localparam logic DIR_RIGHT    = 1'b1;
  localparam int   SEED_W       = 64;

  function automatic logic [SEED_W-1:0] seed(input logic mode, input int unsigned width);
    seed = '0;
    if (mode == MODE_RING && width != 32'd0) begin
      seed[0] = 1'b1;
    end else begin
      seed[0] = 1'b0;
    end
  endfunction

  function automatic int unsigned period(input logic mode, input int unsigned width);
    if (mode == MODE_JOHNSON) begin
      period = 32'd2 * width;
    end else begin
      period = width;
    end
  endfunction

endpackage

// File: rtl/param_ring_counter_if.sv
// Control/status bundle of param_ring_counter; master drives controls, slave is the counter.
interface param_ring_counter_if #(
  parameter int WIDTH = 4
) ();
  localparam int IDX_W = $clog2(2 * WIDTH);

  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] ring_out;
  logic [IDX_W-1:0] step_idx;
  logic             wrap;
  logic             err;

  modport master (
    output en, mode, dir, load, load_val,
    input  ring_out, step_idx, wrap, err
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output ring_out, step_idx, wrap, err
  );
endinterface

// File: rtl/param_ring_counter_check.sv
// Combinational legality check of a ring (one-hot) or Johnson (single-edge) code word.
import ring_counter_pkg::*;

module ring_code_check #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic             mode,
  output logic             legal
);

  logic [WIDTH-2:0] edges_s;

  // Johnson words have at most one boundary between adjacent bits.
  always_comb begin
    edges_s = value[WIDTH-2:0] ^ value[WIDTH-1:1];
    if (mode == MODE_RING) begin
      legal = ($countones(value) == 32'd1);
    end else begin
      legal = ($countones(edges_s) <= 32'd1);
    end
  end

endmodule

// File: rtl/param_ring_counter.sv
// WIDTH-bit ring/Johnson sequencer with direction, load, step index and wrap pulse.
// Optional SELF_CORRECT_EN: reseed on an enabled step from an illegal state and pulse err.
import ring_counter_pkg::*;

module param_ring_counter #(
  parameter  int WIDTH = 4,
  localparam int IDX_W = $clog2(2 * WIDTH)
) (
  input logic               clk,
  input logic               rst,
  param_ring_counter_if.slave bus
);

  logic             mode_q;
  logic [WIDTH-1:0] ring_r;
  logic [IDX_W-1:0] idx_r;
  logic             wrap_r;
  logic             err_r;

  logic [WIDTH-1:0] seed_s;
  logic [IDX_W-1:0] last_idx_s;
  logic [WIDTH-1:0] step_ring_s;
  logic [IDX_W-1:0] step_idx_s;
  logic             inv_s;
  logic             legal_s;

  logic             mode_nx;
  logic [WIDTH-1:0] ring_nx;
  logic [IDX_W-1:0] idx_nx;
  logic             wrap_nx;
  logic             err_nx;

  assign seed_s     = WIDTH'(seed(bus.mode, WIDTH));
  assign last_idx_s = IDX_W'(period(mode_q, WIDTH) - 32'd1);

`ifdef SELF_CORRECT_EN
  ring_code_check #(.WIDTH(WIDTH)) u_check (
    .value (ring_r),
    .mode  (mode_q),
    .legal (legal_s)
  );
`else
  assign legal_s = 1'b1;
`endif

  // Candidate next word and index for one step; Johnson feeds back the inverted end bit.
  always_comb begin
    inv_s = (mode_q == MODE_JOHNSON);
    if (bus.dir == DIR_LEFT) begin
      step_ring_s = {ring_r[WIDTH-2:0], ring_r[WIDTH-1] ^ inv_s};
      step_idx_s  = (idx_r == last_idx_s) ? '0 : idx_r + IDX_W'(1);
    end else begin
      step_ring_s = {ring_r[0] ^ inv_s, ring_r[WIDTH-1:1]};
      step_idx_s  = (idx_r == '0) ? last_idx_s : idx_r - IDX_W'(1);
    end
  end

  // Next-state selection: load > mode change > step > hold.
  always_comb begin
    mode_nx = mode_q;
    ring_nx = ring_r;
    idx_nx  = idx_r;
    wrap_nx = 1'b0;
    err_nx  = 1'b0;
    if (bus.load) begin
      ring_nx = bus.load_val;
      idx_nx  = '0;
    end else if (bus.mode != mode_q) begin
      mode_nx = bus.mode;
      ring_nx = seed_s;
      idx_nx  = '0;
    end else if (bus.en) begin
      if (!legal_s) begin
        ring_nx = seed_s;
        idx_nx  = '0;
        err_nx  = 1'b1;
      end else begin
        ring_nx = step_ring_s;
        idx_nx  = step_idx_s;
        wrap_nx = (step_idx_s == '0);
      end
    end else begin
      ring_nx = ring_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= bus.mode;
      ring_r <= seed_s;
      idx_r  <= '0;
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      mode_q <= mode_nx;
      ring_r <= ring_nx;
      idx_r  <= idx_nx;
      wrap_r <= wrap_nx;
      err_r  <= err_nx;
    end
  end

  assign bus.ring_out = ring_r;
  assign bus.step_idx = idx_r;
  assign bus.wrap     = wrap_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_param_ring_counter.sv
// Randomised and directed bench for param_ring_counter (WIDTH=4) against a behavioural model.
module tb_param_ring_counter;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  int m_mode, m_out, m_idx, m_wrap, m_err;

  param_ring_counter_if #(.WIDTH(W)) bus ();

  param_ring_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int seed_m(input int md);
    return (md != 0) ? 0 : 1;
  endfunction

  function automatic int per_m(input int md);
    return (md != 0) ? 2 * W : W;
  endfunction

  function automatic bit legal_m(input int v, input int md);
    int ones = 0;
    int trans = 0;
    for (int i = 0; i < W; i++) ones += (v >> i) & 1;
    for (int i = 0; i < W - 1; i++)
      if (((v >> i) & 1) != ((v >> (i + 1)) & 1)) trans++;
    return (md == 0) ? (ones == 1) : (trans <= 1);
  endfunction

  // Spec-level model: shifts as multiply/divide by two, feedback bit chosen per mode.
  task automatic model_edge(input int r, input int e, input int md, input int d,
                            input int l, input int lv);
    int top, bot, fb, illegal;
    illegal = 0;
`ifdef SELF_CORRECT_EN
    illegal = !legal_m(m_out, m_mode);
`endif
    m_wrap = 0;
    m_err  = 0;
    if (r == 0) begin
      m_mode = md; m_out = seed_m(md); m_idx = 0;
    end else if (l != 0) begin
      m_out = lv; m_idx = 0;
    end else if (md != m_mode) begin
      m_mode = md; m_out = seed_m(md); m_idx = 0;
    end else if (e != 0) begin
      if (illegal != 0) begin
        m_out = seed_m(m_mode); m_idx = 0; m_err = 1;
      end else begin
        top = m_out / (1 << (W - 1));
        bot = m_out % 2;
        if (d == 0) begin
          fb    = (m_mode != 0) ? 1 - top : top;
          m_out = (m_out * 2) % (1 << W) + fb;
          m_idx = (m_idx + 1) % per_m(m_mode);
        end else begin
          fb    = (m_mode != 0) ? 1 - bot : bot;
          m_out = m_out / 2 + fb * (1 << (W - 1));
          m_idx = (m_idx + per_m(m_mode) - 1) % per_m(m_mode);
        end
        m_wrap = (m_idx == 0);
      end
    end
  endtask

  task automatic cycle(input int r, input int e, input int md, input int d,
                       input int l, input int lv);
    @(negedge clk);
    rst          = r[0];
    bus.en       = e[0];
    bus.mode     = md[0];
    bus.dir      = d[0];
    bus.load     = l[0];
    bus.load_val = lv[W-1:0];
    @(posedge clk);
    model_edge(r, e, md, d, l, lv);
    #1;
    check_val("ring_out", int'(bus.ring_out), m_out);
    check_val("step_idx", int'(bus.step_idx), m_idx);
    check_val("wrap",     int'(bus.wrap),     m_wrap);
    check_val("err",      int'(bus.err),      m_err);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    m_mode = 0; m_out = 0; m_idx = 0; m_wrap = 0; m_err = 0;
    rst = 1'b0; bus.en = 1'b0; bus.mode = 1'b0; bus.dir = 1'b0;
    bus.load = 1'b0; bus.load_val = '0;

    cycle(0, 0, 0, 0, 0, 0);
    check_val("reset_seed", int'(bus.ring_out), 1);
    repeat (5) cycle(1, 1, 0, 0, 0, 0);

    cycle(0, 0, 1, 0, 0, 0);
    repeat (8) cycle(1, 1, 1, 0, 0, 0);
    check_val("johnson_wrap", int'(bus.wrap), 1);

    cycle(0, 0, 0, 0, 0, 0);
    repeat (2) cycle(1, 1, 0, 1, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);

    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 1, 4);
    repeat (4) cycle(1, 1, 0, 0, 0, 0);

    repeat (2) cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    repeat (2) cycle(1, 1, 0, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 0, 0);

    cycle(1, 0, 0, 0, 1, 6);
    cycle(1, 1, 0, 0, 0, 0);
`ifdef SELF_CORRECT_EN
    check_val("illegal_fix", int'(bus.ring_out), 1);
    check_val("illegal_err", int'(bus.err), 1);
`else
    check_val("illegal_rot", int'(bus.ring_out), 12);
    check_val("illegal_err", int'(bus.err), 0);
`endif
    cycle(1, 1, 0, 0, 0, 0);

    for (int k = 0; k < 800; k++) begin
      int r, e, md, d, l, lv;
      r  = ($urandom_range(99) < 3)  ? 0 : 1;
      l  = ($urandom_range(99) < 6)  ? 1 : 0;
      md = ($urandom_range(99) < 5)  ? 1 - m_mode : m_mode;
      e  = ($urandom_range(99) < 75) ? 1 : 0;
      d  = ($urandom_range(99) < 30) ? 1 : 0;
      lv = int'($urandom_range(15));
      cycle(r, e, md, d, l, lv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/param_ring_counter.md
Name: param_ring_counter

Overview:
Parametrised successor to the fixed 4-bit ring counter. It provides a WIDTH-bit shift-sequence counter with runtime-selectable ring (one-hot rotate) or Johnson (twisted-ring) mode, plus direction, enable and parallel load. It also outputs a step index and a wrap pulse. It sits in the sequential-circuits library as a reusable sequencer and strobe generator.

Parameters:
WIDTH, 4, counter width in bits; minimum 2
IDX_W, $clog2(2*WIDTH), width of step_idx; derived, not overridden

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low (rst==0 at posedge resets)
en  input  1  advance one step per clock when high
mode  input  1  0 = ring, 1 = Johnson
dir  input  1  0 = shift left / index up, 1 = shift right / index down
load  input  1  parallel load strobe
load_val  input  WIDTH  value loaded on load
ring_out  output  WIDTH  registered counter state
step_idx  output  IDX_W  steps taken since last seed or load, modulo period
wrap  output  1  one-cycle registered pulse when a step lands on step_idx 0
err  output  1  one-cycle illegal-state pulse; constant 0 unless SELF_CORRECT_EN

Behaviour:
- Period P: WIDTH in ring mode, 2*WIDTH in Johnson mode.
- Seed: ring mode = 0…01; Johnson mode = 0…00.
- Per-edge priority: reset > load > mode change > step (en) > hold.
- Reset: mode_q <= mode. ring_out <= seed(mode). step_idx <= 0. wrap <= 0. err <= 0. Reset mid-sequence discards state; no wrap is issued.
- Load: ring_out <= load_val. step_idx <= 0. wrap <= 0. The loaded value becomes the new home position. en is ignored in that cycle.
- Mode change (mode != mode_q, no load): mode_q <= mode. ring_out <= seed(new mode). step_idx <= 0. No wrap.
- Ring step, left: {out[W-2:0], out[W-1]}. Ring step, right: {out[0], out[W-1:1]}.
- Johnson step, left: {out[W-2:0], ~out[W-1]}. Johnson step, right: {~out[0], out[W-1:1]}.
- step_idx update: left = (idx+1) mod P; right = (idx-1) mod P, so 0 goes to P-1.
- wrap: high for exactly the cycle after a step that makes step_idx 0. Load, reset and mode change never assert wrap.
- en low: all state holds; wrap and err are 0.
- Direction may change on any cycle; it takes effect on the next step with no penalty.
- Legality rules:
  - Ring: popcount(out) == 1.
  - Johnson: at most one i in [0, W-2] with out[i] != out[i+1].
  - Without the optional feature, illegal states rotate unchanged.
- Latency: every output is registered and updates on the same edge as its cause.

Optional Feature:
Macro SELF_CORRECT_EN.
- Defined: on an enabled step whose current ring_out is illegal for mode_q, the block does not shift. It sets ring_out <= seed, step_idx <= 0, err <= 1 for one cycle, and wrap <= 0. A load of an illegal value is accepted; correction happens on the next enabled step.
- Undefined: no legality check is built. err is tied 0 and illegal patterns rotate.

Decomposition:
- Package ring_counter_pkg:
  - MODE_RING = 1'b0, MODE_JOHNSON = 1'b1
  - DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1
  - Functions seed(mode, width) and period(mode, width)
- One combinational sub-module ring_code_check (WIDTH, value, mode -> legal), instantiated only under SELF_CORRECT_EN.

Test Plan (WIDTH=4):
- Ring left: rst=0 for 1 cycle with mode=0, then en=1 dir=0 -> 0001, 0010, 0100, 1000, 0001; step_idx 0,1,2,3,0; wrap high only on the return to 0001.
- Johnson left: mode=1 from reset, en=1 -> 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap on the 8th step; step_idx reaches 7.
- Ring right and mode switch: ring from 0001 with dir=1 -> 1000 (idx 3), 0100 (idx 2). Then mode=1 -> next edge 0000, idx 0, no wrap.
- Load priority: load=1 with load_val=0100 and en=1 -> 0100, idx 0. After 4 left steps -> 0100 again with a wrap pulse.
- Mid-operation reset: after 2 steps (0100), rst=0 for one edge -> 0001, idx 0, wrap 0, err 0. Counting resumes when rst=1.
- Illegal state: ring mode, load 0110, then one enabled left step. With SELF_CORRECT_EN -> 0001, err=1 for 1 cycle. Without it -> 1100, err=0.
